uart_rx_oversample: RTL and testbench

- UART receiver that recovers 8-N-1 serial frames from the `rxd` line.
- Runs entirely in the system `clk` domain. A 16x oversampling tick is generated internally, so no separate receive clock is used.
- Pairs with the existing transmit path: its `rxd` takes the far-end `txd` (or the local `txd` in loopback).
- Delivers each received byte through a valid/ready holding register, with framing and overrun flags.

---
 rtl/uart_rx_oversample.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// 16x-oversampled UART receiver (8-N-1, or 8-E-1 with `UART_RX_PARITY_EN) delivering bytes via a valid/ready holding register.
// Latency: rx_valid rises one clk after the synchronized mid-stop-bit sample; error flags are one-clk pulses.
// Backpressure: a single holding register; a good frame arriving while it is full and not being read is dropped with overrun_err.
module uart_rx_oversample #(
    parameter int TICK_DIV  = 27,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    state_t               nxt;
    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_d;
    logic [TW-1:0]        tcnt;
    logic                 tick;
    logic [3:0]           scnt;
    logic [BW-1:0]        bidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 start_edge;
    logic                 clr_cnt;
    logic                 clr_scnt;
    logic                 shift_en;
    logic                 stop_ok;
    logic                 stop_bad;
    logic                 frame_good;
`ifdef UART_RX_PARITY_EN
    logic                 par_sample;
    logic                 par_bad;
`endif

    assign start_edge = rxs_d & ~rxs;
    assign tick       = (tcnt == TW'(TICK_DIV - 1));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        clr_cnt  = 1'b0;
        clr_scnt = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    clr_cnt = 1'b1;
                    nxt     = START;
                end
            end
            START: begin
                // Mid start bit: a high line here means the edge was a glitch.
                if (tick && scnt == 4'd7) begin
                    if (!rxs) begin
                        clr_scnt = 1'b1;
                        nxt      = DATA;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && scnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bidx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        nxt = PARITY;
`else
                        nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && scnt == 4'd15) begin
                    par_sample = 1'b1;
                    nxt        = STOP;
                end
            end
`endif
            STOP: begin
                // Return to IDLE at mid stop bit so a back-to-back start edge is caught.
                if (tick && scnt == 4'd15) begin
                    nxt = IDLE;
                    if (rxs) begin
                        stop_ok = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
            scnt <= '0;
        end else if (clr_cnt) begin
            tcnt <= '0;
            scnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
            scnt <= clr_scnt ? 4'd0 : scnt + 4'd1;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bidx  <= '0;
            shreg <= '0;
        end else begin
            if (clr_scnt) begin
                bidx <= '0;
            end else if (shift_en) begin
                bidx <= bidx + BW'(1);
            end
            if (shift_en) begin
                shreg <= {rxs, shreg[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_sample) begin
                par_bad <= rxs ^ (^shreg);
            end
            parity_err <= stop_ok & par_bad;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            framing_err <= 1'b0;
            frame_good  <= 1'b0;
        end else begin
            framing_err <= stop_bad;
`ifdef UART_RX_PARITY_EN
            frame_good  <= stop_ok & ~par_bad;
`else
            frame_good  <= stop_ok;
`endif
        end
    end

    // shreg is stable for a full bit after the last shift, so it can be loaded one clk late.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_good && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else begin
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
                if (frame_good) begin
                    overrun_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample at TICK_DIV=4 (64 clk per bit); build with +define+UART_RX_PARITY_EN for the 8-E-1 variant.
module tb_uart_rx_oversample;
    localparam int TD   = 4;
    localparam int BITC = 16 * TD;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;

    uart_rx_oversample #(.TICK_DIV(TD), .DATA_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Each high cycle counts, so a two-clk pulse shows up as an extra count.
    always @(negedge clk) begin
        if (framing_err) fe_cnt++;
        if (overrun_err) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       rdy;
        logic       drain;
        logic       exp_v;
        logic [7:0] exp_d;
        int         exp_fe;
        int         exp_ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start, data and (optionally) parity bits; returns right before the stop bit.
    task automatic send_head(input logic [7:0] d, input logic par);
        rxd = 1'b0;
        wait_clk(BITC);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clk(BITC);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par;
        wait_clk(BITC);
`else
        if (par === 1'bx) rxd = 1'b0;
`endif
    endtask

    task automatic send_bits(input logic [7:0] d, input logic par, input logic stop);
        send_head(d, par);
        rxd = stop;
        wait_clk(BITC);
        rxd = 1'b1;
    endtask

    initial begin
        vec_t tbl[5];
        int fe0;
        int ov0;
        int pe0;

        tbl[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 0};
        tbl[1] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 1};
        tbl[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1, 0};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 0, 0};

        rst = 1'b1;
        rxd = 1'b1;
        rx_ready = 1'b0;
        wait_clk(3);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clk(5);

        // 0xA5: rx_valid rises exactly one clk after the synchronized mid-stop sample.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_head(8'hA5, ^8'hA5);
        rxd = 1'b1;
        wait_clk(35);
        check("a5_valid_before", {31'd0, rx_valid}, 32'd0);
        wait_clk(1);
        check("a5_valid_after", {31'd0, rx_valid}, 32'd1);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        wait_clk(30);
        check("a5_no_fe", fe_cnt - fe0, 32'd0);
        check("a5_no_ov", ov_cnt - ov0, 32'd0);
        rx_ready = 1'b1;
        wait_clk(1);
        check("a5_drain", {31'd0, rx_valid}, 32'd0);
        rx_ready = 1'b0;
        wait_clk(10);

        for (int i = 0; i < 5; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            rx_ready = tbl[i].rdy;
            send_bits(tbl[i].d, ^tbl[i].d, tbl[i].stop);
            wait_clk(4);
            check($sformatf("vec%0d_valid", i), {31'd0, rx_valid}, {31'd0, tbl[i].exp_v});
            check($sformatf("vec%0d_data", i), {24'd0, rx_data}, {24'd0, tbl[i].exp_d});
            check($sformatf("vec%0d_fe", i), fe_cnt - fe0, tbl[i].exp_fe);
            check($sformatf("vec%0d_ov", i), ov_cnt - ov0, tbl[i].exp_ov);
            if (tbl[i].drain) begin
                rx_ready = 1'b1;
                wait_clk(1);
                check($sformatf("vec%0d_drain", i), {31'd0, rx_valid}, 32'd0);
            end
            rx_ready = 1'b0;
            wait_clk(6);
        end

        // Framing error with the line then held low: no retrigger without an edge.
        fe0 = fe_cnt;
        send_head(8'h55, ^8'h55);
        rxd = 1'b0;
        wait_clk(BITC + 200);
        check("low_hold_busy", {31'd0, busy}, 32'd0);
        check("low_hold_valid", {31'd0, rx_valid}, 32'd0);
        check("low_hold_fe", fe_cnt - fe0, 32'd1);
        rxd = 1'b1;
        wait_clk(BITC);
        check("low_release_busy", {31'd0, busy}, 32'd0);

        // Good frame landing in the same cycle as the handshake: no overrun, new byte kept.
        send_bits(8'h11, ^8'h11, 1'b1);
        wait_clk(4);
        check("hs_first", {24'd0, rx_data}, 32'h11);
        ov0 = ov_cnt;
        send_head(8'h22, ^8'h22);
        rxd = 1'b1;
        wait_clk(35);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        check("hs_same_valid", {31'd0, rx_valid}, 32'd1);
        check("hs_same_data", {24'd0, rx_data}, 32'h22);
        wait_clk(30);
        check("hs_same_ov", ov_cnt - ov0, 32'd0);

        // Short glitch: START aborts at mid bit, outputs untouched.
        fe0 = fe_cnt;
        rxd = 1'b0;
        wait_clk(20);
        rxd = 1'b1;
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        wait_clk(30);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check("glitch_valid", {31'd0, rx_valid}, 32'd1);
        check("glitch_data", {24'd0, rx_data}, 32'h22);
        check("glitch_fe", fe_cnt - fe0, 32'd0);

        // Reset at bit 4 of 0xFF, then 0x81 must be the only byte delivered.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rxd = 1'b0;
        wait_clk(BITC);
        rxd = 1'b1;
        wait_clk(4 * BITC + BITC / 2);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_data", {24'd0, rx_data}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_fe", {31'd0, framing_err}, 32'd0);
        check("rst_mid_ov", {31'd0, overrun_err}, 32'd0);
        wait_clk(6 * BITC);
        check("rst_nothing_loaded", {31'd0, rx_valid}, 32'd0);
        send_bits(8'h81, ^8'h81, 1'b1);
        wait_clk(4);
        check("rst_then_valid", {31'd0, rx_valid}, 32'd1);
        check("rst_then_data", {24'd0, rx_data}, 32'h81);
        check("rst_then_fe", fe_cnt - fe0, 32'd0);
        check("rst_then_ov", ov_cnt - ov0, 32'd0);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        wait_clk(10);

`ifdef UART_RX_PARITY_EN
        pe0 = pe_cnt;
        send_bits(8'h07, 1'b0, 1'b1);
        wait_clk(4);
        check("par_bad_pe", pe_cnt - pe0, 32'd1);
        check("par_bad_valid", {31'd0, rx_valid}, 32'd0);
        pe0 = pe_cnt;
        send_bits(8'h07, 1'b1, 1'b1);
        wait_clk(4);
        check("par_good_pe", pe_cnt - pe0, 32'd0);
        check("par_good_valid", {31'd0, rx_valid}, 32'd1);
        check("par_good_data", {24'd0, rx_data}, 32'h07);
`else
        pe0 = pe_cnt;
        check("no_parity_pulses", pe_cnt - pe0 + {31'd0, rx_valid}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
